exec_unit_p: RTL and testbench

Parametrised execution unit: a WIDTH-bit register file of NREGS entries plus an ALU with a 4-bit flag register, driven by a valid/ready command port. It is the next-generation core of `eucl`. It replaces the fixed 6×8 register/ALU block with one that updates flags in the same cycle as the result. Ops run on arbitrary source and destination registers, with no scratch registers. Each command produces a one-cycle response pulse.

---
 rtl/exec_unit_pkg.sv | 34 +++
 rtl/exec_unit_p_alu.sv | 73 +++++++
 rtl/exec_unit_p.sv | 136 +++++++++++++
 tb/tb_exec_unit_p.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_unit_pkg.sv
// Shared types and constants for the exec_unit_p register/ALU core.
package exec_unit_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_LSL = 4'd4,
        OP_LSR = 4'd5,
        OP_CMP = 4'd6,
        OP_DEC = 4'd7,
        OP_MOV = 4'd8,
        OP_INC = 4'd9,
        OP_LDI = 4'd10,
        OP_RD  = 4'd11,
        OP_ADC = 4'd12,
        OP_SBB = 4'd13
    } op_e;

    localparam int unsigned FLG_Z  = 0;
    localparam int unsigned FLG_G  = 1;
    localparam int unsigned FLG_S  = 2;
    localparam int unsigned FLG_C  = 3;
    localparam int unsigned FLAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/exec_unit_p_alu.sv
// Combinational ALU: computes result, write enable and per-op flag update.
module exec_alu
    import exec_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [3:0]        op_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    input  logic [WIDTH-1:0]  imm_i,
    input  logic              c_i,
    output logic [WIDTH-1:0]  res_c_o,
    output logic              we_c_o,
    output logic [FLAG_W-1:0] fmask_c_o,
    output logic [FLAG_W-1:0] fnext_c_o,
    output logic              illegal_c_o
);

    localparam int unsigned XW = WIDTH + 1;

    logic [XW-1:0] a_x;
    logic [XW-1:0] b_x;
    logic [XW-1:0] sum;

    // Arithmetic at WIDTH+1 bits so the top bit is carry or borrow.
    always_comb begin
        a_x         = {1'b0, a_i};
        b_x         = {1'b0, b_i};
        sum         = '0;
        we_c_o      = 1'b0;
        fmask_c_o   = '0;
        fnext_c_o   = '0;
        illegal_c_o = 1'b0;
        case (op_i)
            OP_ADD: begin sum = a_x + b_x; we_c_o = 1'b1; fmask_c_o[FLG_C] = 1'b1; fmask_c_o[FLG_Z] = 1'b1; end
            OP_SUB: begin sum = a_x - b_x; we_c_o = 1'b1; fmask_c_o[FLG_C] = 1'b1; fmask_c_o[FLG_Z] = 1'b1; end
            OP_AND: begin sum = {1'b0, a_i & b_i}; we_c_o = 1'b1; fmask_c_o[FLG_Z] = 1'b1; end
            OP_OR:  begin sum = {1'b0, a_i | b_i}; we_c_o = 1'b1; fmask_c_o[FLG_Z] = 1'b1; end
            OP_LSL: begin
                sum = {1'b0, a_i[WIDTH-2:0], 1'b0};
                we_c_o = 1'b1;
                fnext_c_o[FLG_S] = a_i[WIDTH-1];
                fmask_c_o[FLG_S] = 1'b1;
                fmask_c_o[FLG_Z] = 1'b1;
            end
            OP_LSR: begin
                sum = {2'b00, a_i[WIDTH-1:1]};
                we_c_o = 1'b1;
                fnext_c_o[FLG_S] = a_i[0];
                fmask_c_o[FLG_S] = 1'b1;
                fmask_c_o[FLG_Z] = 1'b1;
            end
            OP_CMP: begin
                sum = a_x - b_x;
                fnext_c_o[FLG_G] = (a_i > b_i);
                fmask_c_o[FLG_G] = 1'b1;
                fmask_c_o[FLG_Z] = 1'b1;
            end
            OP_DEC: begin sum = a_x - XW'(1); we_c_o = 1'b1; fmask_c_o[FLG_C] = 1'b1; fmask_c_o[FLG_Z] = 1'b1; end
            OP_MOV: begin sum = a_x; we_c_o = 1'b1; end
            OP_INC: begin sum = a_x + XW'(1); we_c_o = 1'b1; fmask_c_o[FLG_C] = 1'b1; fmask_c_o[FLG_Z] = 1'b1; end
            OP_LDI: begin sum = {1'b0, imm_i}; we_c_o = 1'b1; end
            OP_RD:  begin sum = a_x; end
            OP_ADC: begin sum = a_x + b_x + XW'(c_i); we_c_o = 1'b1; fmask_c_o[FLG_C] = 1'b1; fmask_c_o[FLG_Z] = 1'b1; end
            OP_SBB: begin sum = a_x - b_x - XW'(c_i); we_c_o = 1'b1; fmask_c_o[FLG_C] = 1'b1; fmask_c_o[FLG_Z] = 1'b1; end
            default: illegal_c_o = 1'b1;
        endcase
        res_c_o          = sum[WIDTH-1:0];
        fnext_c_o[FLG_C] = sum[WIDTH];
        fnext_c_o[FLG_Z] = (sum[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/exec_unit_p.sv
// Register file + ALU core with a 4-state command FSM and single-cycle response pulse.
module exec_unit_p
    import exec_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREGS = 8,
    localparam int unsigned AW = $clog2(NREGS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [AW-1:0]     cmd_rd,
    input  logic [AW-1:0]     cmd_rs1,
    input  logic [AW-1:0]     cmd_rs2,
    input  logic [WIDTH-1:0]  cmd_imm,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_data,
    output logic              rsp_err,
    output logic [FLAG_W-1:0] flags
);

    state_e state_q, state_d;
    logic   ready_q, ready_d;

    logic [3:0]        op_q;
    logic [AW-1:0]     rd_q, rs1_q, rs2_q;
    logic [WIDTH-1:0]  imm_q, a_q, b_q, res_q;
    logic              we_q, err_q;
    logic [FLAG_W-1:0] flags_q, flags_nx_q;
    logic              rsp_valid_q, rsp_err_q;
    logic [WIDTH-1:0]  rsp_data_q;
    logic [WIDTH-1:0]  regs_q [NREGS];

    logic [WIDTH-1:0]  alu_res;
    logic              alu_we, alu_ill;
    logic [FLAG_W-1:0] alu_mask, alu_fnext;

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign flags     = flags_q;

    exec_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i        (op_q),
        .a_i         (a_q),
        .b_i         (b_q),
        .imm_i       (imm_q),
        .c_i         (flags_q[FLG_C]),
        .res_c_o     (alu_res),
        .we_c_o      (alu_we),
        .fmask_c_o   (alu_mask),
        .fnext_c_o   (alu_fnext),
        .illegal_c_o (alu_ill)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_READ;
            ST_READ: state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // Command capture, operand fetch, execute and response pipeline.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
            flags_nx_q  <= '0;
            flags_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= (state_q == ST_WB);
            if (state_q == ST_IDLE && cmd_valid) begin
                op_q  <= cmd_op;
                rd_q  <= cmd_rd;
                rs1_q <= cmd_rs1;
                rs2_q <= cmd_rs2;
                imm_q <= cmd_imm;
            end
            if (state_q == ST_READ) begin
                a_q <= regs_q[rs1_q];
                b_q <= regs_q[rs2_q];
            end
            // ADC/SBB see committed C: the previous command finished its WB already.
            if (state_q == ST_EXEC) begin
                res_q      <= alu_res;
                we_q       <= alu_we;
                err_q      <= alu_ill;
                flags_nx_q <= (flags_q & ~alu_mask) | (alu_fnext & alu_mask);
            end
            if (state_q == ST_WB) begin
                flags_q    <= flags_nx_q;
                rsp_data_q <= res_q;
                rsp_err_q  <= err_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else if (state_q == ST_WB && we_q) begin
            regs_q[rd_q] <= res_q;
        end
    end

endmodule

// File: tb/tb_exec_unit_p.sv
// Bench for exec_unit_p: 8x8 and 16x16 instances driven with the same command stream.
module tb_exec_unit_p;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic [15:0] cmd_imm;

    logic        rdy8, rv8, err8;
    logic [7:0]  rd8;
    logic [3:0]  fl8;
    logic        rdy16, rv16, err16;
    logic [15:0] rd16;
    logic [3:0]  fl16;

    int checks = 0;
    int errors = 0;

    int unsigned m8 [8];
    int unsigned m16 [16];
    logic [3:0]  f8, f16;

    always #5 clock = ~clock;

    exec_unit_p #(.WIDTH(8), .NREGS(8)) dut8 (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(rdy8),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd[2:0]), .cmd_rs1(cmd_rs1[2:0]), .cmd_rs2(cmd_rs2[2:0]),
        .cmd_imm(cmd_imm[7:0]), .rsp_valid(rv8), .rsp_data(rd8), .rsp_err(err8), .flags(fl8)
    );

    exec_unit_p #(.WIDTH(16), .NREGS(16)) dut16 (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(rdy16),
        .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
        .cmd_imm(cmd_imm), .rsp_valid(rv16), .rsp_data(rd16), .rsp_err(err16), .flags(fl16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Architectural reference: each opcode's rule as plain integer arithmetic.
    function automatic void model(input int unsigned w, input logic [3:0] op,
                                  input int unsigned a, input int unsigned b, input int unsigned imm,
                                  input logic [3:0] fi, output int unsigned res, output bit we,
                                  output logic [3:0] fo, output bit err);
        int unsigned mask, c;
        mask = (32'd1 << w) - 32'd1;
        c    = {31'd0, fi[3]};
        fo   = fi;
        we   = 1'b1;
        err  = 1'b0;
        res  = 0;
        case (op)
            4'd0:  begin res = (a + b) & mask; fo[3] = (a + b) > mask; end
            4'd1:  begin res = (a - b) & mask; fo[3] = a < b; end
            4'd2:  res = a & b;
            4'd3:  res = a | b;
            4'd4:  begin res = (a << 1) & mask; fo[2] = ((a >> (w - 1)) & 1) != 0; end
            4'd5:  begin res = a >> 1; fo[2] = (a & 1) != 0; end
            4'd6:  begin res = (a - b) & mask; we = 1'b0; fo[1] = a > b; fo[0] = a == b; end
            4'd7:  begin res = (a - 1) & mask; fo[3] = a == 0; end
            4'd8:  res = a;
            4'd9:  begin res = (a + 1) & mask; fo[3] = a == mask; end
            4'd10: res = imm & mask;
            4'd11: begin res = a; we = 1'b0; end
            4'd12: begin res = (a + b + c) & mask; fo[3] = (a + b + c) > mask; end
            4'd13: begin res = (a - b - c) & mask; fo[3] = a < (b + c); end
            default: begin we = 1'b0; err = 1'b1; end
        endcase
        if (op inside {[4'd0:4'd5], 4'd7, 4'd9, 4'd12, 4'd13}) fo[0] = (res == 0);
    endfunction

    task automatic model_reset();
        foreach (m8[i]) m8[i] = 0;
        foreach (m16[i]) m16[i] = 0;
        f8  = 4'd0;
        f16 = 4'd0;
    endtask

    // One full command on both instances; checks latency, pulse width and model results.
    task automatic do_cmd(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                          input int unsigned imm, output logic [7:0] d8, output logic [3:0] fo8,
                          output logic e8);
        int unsigned r8, r16;
        bit w8, w16, x8, x16;
        logic [3:0] nf8, nf16;
        int n;
        model(8, op, m8[rs1 & 7], m8[rs2 & 7], imm & 32'hFF, f8, r8, w8, nf8, x8);
        model(16, op, m16[rs1 & 15], m16[rs2 & 15], imm & 32'hFFFF, f16, r16, w16, nf16, x16);
        @(negedge clock);
        chk("cmd_ready8", 32'(rdy8), 32'd1);
        chk("cmd_ready16", 32'(rdy16), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = 4'(rd);
        cmd_rs1   = 4'(rs1);
        cmd_rs2   = 4'(rs2);
        cmd_imm   = 16'(imm);
        @(negedge clock);
        cmd_valid = 1'b0;
        n = 1;
        while (!rv8 && n < 10) begin
            @(negedge clock);
            n++;
        end
        chk("latency", 32'(n), 32'd4);
        chk("rsp_valid16", 32'(rv16), 32'd1);
        chk("rsp_data8", 32'(rd8), 32'(r8));
        chk("rsp_err8", 32'(err8), 32'(x8));
        chk("flags8", 32'(fl8), 32'(nf8));
        chk("rsp_data16", 32'(rd16), 32'(r16));
        chk("rsp_err16", 32'(err16), 32'(x16));
        chk("flags16", 32'(fl16), 32'(nf16));
        d8  = rd8;
        fo8 = fl8;
        e8  = err8;
        @(negedge clock);
        chk("rsp_pulse8", 32'(rv8), 32'd0);
        chk("rsp_pulse16", 32'(rv16), 32'd0);
        chk("rsp_hold8", 32'(rd8), 32'(r8));
        if (w8) m8[rd & 7] = r8;
        if (w16) m16[rd & 15] = r16;
        f8  = nf8;
        f16 = nf16;
    endtask

    typedef struct {
        logic [3:0]  op;
        int          rd;
        int          rs1;
        int          rs2;
        int unsigned imm;
        logic [7:0]  ed;
        logic [3:0]  ef;
        logic        ee;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic [3:0] op, input int rd, input int rs1, input int rs2,
                               input int unsigned imm, input logic [7:0] ed, input logic [3:0] ef,
                               input logic ee);
        vec_t t;
        t.op = op; t.rd = rd; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm;
        t.ed = ed; t.ef = ef; t.ee = ee;
        return t;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d8;
        logic [3:0] fo8;
        logic       e8;

        // Expected values are for the 8-bit instance; flags as {C,S,G,Z}.
        tbl.push_back(v(4'd10, 1, 0, 0, 32'h7F, 8'h7F, 4'b0000, 1'b0)); // LDI r1
        tbl.push_back(v(4'd10, 2, 0, 0, 32'h01, 8'h01, 4'b0000, 1'b0)); // LDI r2
        tbl.push_back(v(4'd0,  3, 1, 2, 0,      8'h80, 4'b0000, 1'b0)); // ADD
        tbl.push_back(v(4'd11, 0, 3, 0, 0,      8'h80, 4'b0000, 1'b0)); // RD r3
        tbl.push_back(v(4'd10, 1, 0, 0, 32'hFF, 8'hFF, 4'b0000, 1'b0));
        tbl.push_back(v(4'd9,  1, 1, 0, 0,      8'h00, 4'b1001, 1'b0)); // INC wraps
        tbl.push_back(v(4'd12, 4, 2, 2, 0,      8'h03, 4'b0000, 1'b0)); // ADC uses C=1
        tbl.push_back(v(4'd10, 1, 0, 0, 32'h05, 8'h05, 4'b0000, 1'b0));
        tbl.push_back(v(4'd10, 2, 0, 0, 32'h03, 8'h03, 4'b0000, 1'b0));
        tbl.push_back(v(4'd10, 5, 0, 0, 32'h01, 8'h01, 4'b0000, 1'b0));
        tbl.push_back(v(4'd5,  6, 5, 0, 0,      8'h00, 4'b0101, 1'b0)); // LSR 0x01
        tbl.push_back(v(4'd10, 7, 0, 0, 32'h00, 8'h00, 4'b0101, 1'b0));
        tbl.push_back(v(4'd7,  7, 7, 0, 0,      8'hFF, 4'b1100, 1'b0)); // DEC 0 borrows
        tbl.push_back(v(4'd6,  0, 1, 2, 0,      8'h02, 4'b1110, 1'b0)); // CMP 5,3
        tbl.push_back(v(4'd6,  0, 2, 2, 0,      8'h00, 4'b1101, 1'b0)); // CMP 3,3
        tbl.push_back(v(4'd10, 6, 0, 0, 32'h81, 8'h81, 4'b1101, 1'b0));
        tbl.push_back(v(4'd4,  6, 6, 0, 0,      8'h02, 4'b1100, 1'b0)); // LSL 0x81
        tbl.push_back(v(4'd15, 0, 1, 2, 0,      8'h00, 4'b1100, 1'b1)); // illegal
        tbl.push_back(v(4'd11, 0, 1, 0, 0,      8'h05, 4'b1100, 1'b0));
        tbl.push_back(v(4'd11, 0, 2, 0, 0,      8'h03, 4'b1100, 1'b0));
        tbl.push_back(v(4'd11, 0, 6, 0, 0,      8'h02, 4'b1100, 1'b0));
        tbl.push_back(v(4'd11, 0, 4, 0, 0,      8'h03, 4'b1100, 1'b0));
        tbl.push_back(v(4'd11, 0, 7, 0, 0,      8'hFF, 4'b1100, 1'b0));
        tbl.push_back(v(4'd11, 0, 0, 0, 0,      8'h00, 4'b1100, 1'b0)); // r0 untouched
        tbl.push_back(v(4'd13, 0, 2, 1, 0,      8'hFD, 4'b1100, 1'b0)); // SBB 3-5-1
        tbl.push_back(v(4'd1,  0, 1, 1, 0,      8'h00, 4'b0101, 1'b0)); // SUB self
        tbl.push_back(v(4'd3,  3, 1, 2, 0,      8'h07, 4'b0100, 1'b0));
        tbl.push_back(v(4'd2,  3, 1, 2, 0,      8'h01, 4'b0100, 1'b0));
        tbl.push_back(v(4'd8,  5, 1, 0, 0,      8'h05, 4'b0100, 1'b0));
        tbl.push_back(v(4'd11, 0, 5, 0, 0,      8'h05, 4'b0100, 1'b0));
        tbl.push_back(v(4'd10, 3, 0, 0, 32'h00, 8'h00, 4'b0100, 1'b0));
        tbl.push_back(v(4'd10, 2, 0, 0, 32'h01, 8'h01, 4'b0100, 1'b0));
        tbl.push_back(v(4'd1,  4, 3, 2, 0,      8'hFF, 4'b1100, 1'b0)); // 0-1 borrows

        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_rd    = 4'd0;
        cmd_rs1   = 4'd0;
        cmd_rs2   = 4'd0;
        cmd_imm   = 16'd0;
        model_reset();
        repeat (3) @(negedge clock);
        chk("reset_ready8", 32'(rdy8), 32'd1);
        chk("reset_rsp_valid8", 32'(rv8), 32'd0);
        chk("reset_rsp_data16", 32'(rd16), 32'd0);
        chk("reset_flags8", 32'(fl8), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        chk("post_reset_ready16", 32'(rdy16), 32'd1);

        foreach (tbl[i]) begin
            do_cmd(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, d8, fo8, e8);
            chk($sformatf("vec%0d_data", i), 32'(d8), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_flags", i), 32'(fo8), 32'(tbl[i].ef));
            chk($sformatf("vec%0d_err", i), 32'(e8), 32'(tbl[i].ee));
        end
        chk("sub16_data", 32'(rd16), 32'h0000FFFF);
        chk("sub16_carry", 32'(fl16[3]), 32'd1);

        // Back-to-back: cmd_valid held high across four RD commands.
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_op    = 4'd11;
        cmd_rs1   = 4'd1;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("b2b_ready_%0d", k), 32'(rdy8), 32'((k % 4) == 0));
            chk($sformatf("b2b_rsp_%0d", k), 32'(rv16), 32'(((k % 4) == 0) && (k > 0)));
            @(negedge clock);
        end
        cmd_valid = 1'b0;
        chk("b2b_rsp_last", 32'(rv8), 32'd1);
        chk("b2b_data_last", 32'(rd8), 32'h05);
        @(negedge clock);

        // Reset asserted while ADD r3 is in EXEC.
        cmd_valid = 1'b1;
        cmd_op    = 4'd0;
        cmd_rd    = 4'd3;
        cmd_rs1   = 4'd1;
        cmd_rs2   = 4'd2;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("midreset_ready8", 32'(rdy8), 32'd1);
        chk("midreset_flags16", 32'(fl16), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("midreset_no_rsp8", 32'(rv8), 32'd0);
            chk("midreset_no_rsp16", 32'(rv16), 32'd0);
        end
        reset_n = 1'b1;
        model_reset();
        for (int r = 0; r < 16; r++) begin
            do_cmd(4'd11, 0, r, 0, 0, d8, fo8, e8);
        end

        // Randomised commands against the reference model.
        for (int i = 0; i < 400; i++) begin
            do_cmd(4'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   $urandom & 32'hFFFF, d8, fo8, e8);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
